frame_sequencer: RTL
====================

Name: frame_sequencer

Overview:
- Produces the slot-select strobes (signal_f1, signal_f2, signal_d) and the 16-bit subframe counter (sf_count) for the downstream output-word mux.
- Frame layout, one slot per word_tick:
  - F1 sync slot
  - F2 sync slot
  - SF slot (all selects low, so the mux passes sf_count)
  - DATA_WORDS data slots (signal_d high, so the mux passes count)
- Sits between the serializer's word-rate strobe and the output-word mux. It also gives the data counter upstream of the mux an advance pulse.

Parameters:
- DATA_WORDS, 64, data slots per frame; legal range 1..65535.
- IDX_W, 16, width of the internal data-slot index; must satisfy 2^IDX_W > DATA_WORDS-1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  frame generation enable; level-sensitive.
- word_tick  input  1  one-cycle strobe from the serializer: the current word has been consumed and the slot advances.
- sf_clear  input  1  synchronous clear of sf_count.
- signal_f1  output  1  high during the F1 slot.
- signal_f2  output  1  high during the F2 slot.
- signal_d  output  1  high during data slots.
- sf_count  output  16  subframe counter.
- word_valid  output  1  high in any non-IDLE state; the mux output is meaningful.
- data_adv  output  1  one-cycle pulse that tells the upstream data counter to step.
- frame_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, all outputs 0, sf_count=0, index=0.
- Reset asserted mid-frame aborts the frame immediately. No frame_done is issued.
- States and outputs; all outputs are registered, decoded from state:
  - IDLE: all selects 0, word_valid=0.
  - F1: signal_f1=1.
  - F2: signal_f2=1.
  - SF: all selects 0, word_valid=1.
  - DATA: signal_d=1.
- Selects are one-hot or all-zero; two selects are never high in the same cycle.
- Transitions happen only in a cycle where word_tick=1; the new state appears on the following cycle:
  - IDLE -> F1 if enable=1; otherwise stay in IDLE.
  - F1 -> F2.
  - F2 -> SF.
  - SF -> DATA, with index cleared to 0.
  - DATA with index < DATA_WORDS-1 -> DATA, with index +1.
  - DATA with index = DATA_WORDS-1 -> F1 if enable=1, else IDLE.
- enable deassertion mid-frame does not truncate the frame. The current frame completes, and enable is sampled only at IDLE and at the last data tick.
- data_adv: registered, asserted the cycle after each word_tick taken in DATA. Exactly DATA_WORDS pulses per frame.
- frame_done: registered, asserted the cycle after the last data tick, coincident with the new state.
- sf_count increments by 1 on the word_tick that leaves SF. The frame therefore transmits the pre-increment value, and the next frame carries value+1.
- sf_count wraps 0xFFFF -> 0x0000 with no flag.
- sf_clear has priority over the increment when both occur in the same cycle, giving 0 next cycle. sf_clear is legal in any state.
- Back-to-back word_tick on consecutive cycles is legal and advances one slot per cycle. Ticks have no effect in IDLE while enable=0.

Decomposition:
- Shared package frame_pkg holds:
  - state encoding constants ST_IDLE, ST_F1, ST_F2, ST_SF, ST_DATA (3-bit);
  - the default DATA_WORDS;
  - the 16-bit word width constant, shared with the output-word mux.
- One sub-module, frame_slot_counter: DATA_WORDS index counter with clear/increment and a last-slot flag.
- The FSM, sf_count and the pulse registers stay in the top.

Test Plan (DATA_WORDS=4):
- Reset release, enable=1, word_tick every cycle -> select sequence F1, F2, SF, D, D, D, D, F1 on consecutive cycles; sf_count reads 0 during the first SF slot and 1 during the second.
- Same stimulus, check pulses -> exactly 4 data_adv pulses per frame; frame_done fires once, coincident with the second F1.
- enable dropped during the second data slot -> remaining data slots complete, then IDLE with word_valid=0; later ticks produce no change.
- sf_count preset to 0xFFFF via 65535 frames (or forced), SF tick -> next frame shows 0x0000; sf_clear on the same cycle as the SF tick -> 0x0000.
- word_tick every 5th cycle -> outputs hold between ticks; frame length = 7 ticks = 35 cycles.
- rst_n pulsed low asynchronously mid-DATA -> all outputs 0 immediately; no frame_done; after release with enable=1, the first tick yields F1.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared definitions for the frame sequencer and the downstream output-word mux.
package frame_pkg;

    localparam int WORD_W             = 16;
    localparam int DEFAULT_DATA_WORDS = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F1   = 3'd1,
        ST_F2   = 3'd2,
        ST_SF   = 3'd3,
        ST_DATA = 3'd4
    } state_t;

endpackage

// File: rtl/frame_slot_counter.sv
// Data-slot index within a frame; flags the final data slot so the FSM can wrap.
module frame_slot_counter
    import frame_pkg::*;
#(
    parameter int DATA_WORDS = DEFAULT_DATA_WORDS,
    parameter int IDX_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WORDS - 1);

    logic [IDX_W-1:0] index;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
        end else if (clr) begin
            index <= '0;
        end else if (inc) begin
            index <= index + IDX_W'(1);
        end
    end

    assign last = (index == LAST_IDX);

endmodule

// File: rtl/frame_sequencer.sv
// Slot sequencer: F1, F2, SF, then DATA_WORDS data slots, advancing once per word_tick.
module frame_sequencer
    import frame_pkg::*;
#(
    parameter int DATA_WORDS = DEFAULT_DATA_WORDS,
    parameter int IDX_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              word_tick,
    input  logic              sf_clear,
    output logic              signal_f1,
    output logic              signal_f2,
    output logic              signal_d,
    output logic [WORD_W-1:0] sf_count,
    output logic              word_valid,
    output logic              data_adv,
    output logic              frame_done
);

    state_t            state;
    state_t            next_state;
    logic              slot_clr;
    logic              slot_inc;
    logic              slot_last;
    logic              adv_next;
    logic              done_next;
    logic [WORD_W-1:0] sf_next;

    frame_slot_counter #(
        .DATA_WORDS (DATA_WORDS),
        .IDX_W      (IDX_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (slot_clr),
        .inc   (slot_inc),
        .last  (slot_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            data_adv   <= 1'b0;
            frame_done <= 1'b0;
            sf_count   <= '0;
        end else begin
            state      <= next_state;
            data_adv   <= adv_next;
            frame_done <= done_next;
            sf_count   <= sf_next;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        slot_clr   = 1'b0;
        slot_inc   = 1'b0;
        adv_next   = 1'b0;
        done_next  = 1'b0;
        if (word_tick) begin
            case (state)
                ST_IDLE: if (enable) next_state = ST_F1;
                ST_F1:   next_state = ST_F2;
                ST_F2:   next_state = ST_SF;
                ST_SF: begin
                    next_state = ST_DATA;
                    slot_clr   = 1'b1;
                end
                ST_DATA: begin
                    adv_next = 1'b1;
                    if (slot_last) begin
                        // enable is only looked at here and in IDLE; frames never truncate
                        next_state = enable ? ST_F1 : ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        slot_inc = 1'b1;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Clear wins over the increment taken when leaving the SF slot.
    always_comb begin
        sf_next = sf_count;
        if (sf_clear) begin
            sf_next = '0;
        end else if (word_tick && (state == ST_SF)) begin
            sf_next = sf_count + WORD_W'(1);
        end
    end

    always_comb begin
        signal_f1  = 1'b0;
        signal_f2  = 1'b0;
        signal_d   = 1'b0;
        word_valid = 1'b1;
        case (state)
            ST_IDLE: word_valid = 1'b0;
            ST_F1:   signal_f1  = 1'b1;
            ST_F2:   signal_f2  = 1'b1;
            ST_SF:   word_valid = 1'b1;
            ST_DATA: signal_d   = 1'b1;
            default: word_valid = 1'b0;
        endcase
    end

endmodule
